seq_detector: RTL and testbench

SEQ_DETECTOR -- requirements
Module: seq_detector

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_detector_if.sv | 31 +++
 rtl/seq_det_sat_counter.sv | 38 +++
 rtl/seq_detector.sv | 126 ++++++++++++
 tb/tb_seq_detector.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared definitions for the serial pattern detector: the control FSM
//   state encoding and the default parameter values used by the interface
//   and the top level.
package seq_det_pkg;

    // UNCONF: no pattern loaded yet, input stream ignored.
    // RUN   : pattern loaded, stream is being matched.
    typedef enum logic {
        UNCONF = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int DEF_PAT_W   = 4;
    localparam int DEF_CNT_W   = 8;
    localparam bit DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_detector_if.sv
// seq_detector_if
//   Groups the detector's stream, configuration and status signals.
//   master: drives EN/In1/PAT_LOAD/PAT_IN/CNT_CLR, observes status.
//   slave : the detector; consumes the inputs, drives Out1/MATCH_CNT/
//           CNT_SAT/ARMED.
interface seq_detector_if
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic             EN;
    logic             In1;
    logic             PAT_LOAD;
    logic [PAT_W-1:0] PAT_IN;
    logic             CNT_CLR;
    logic             Out1;
    logic [CNT_W-1:0] MATCH_CNT;
    logic             CNT_SAT;
    logic             ARMED;

    modport master (
        output EN, In1, PAT_LOAD, PAT_IN, CNT_CLR,
        input  Out1, MATCH_CNT, CNT_SAT, ARMED
    );

    modport slave (
        input  EN, In1, PAT_LOAD, PAT_IN, CNT_CLR,
        output Out1, MATCH_CNT, CNT_SAT, ARMED
    );
endinterface

// File: rtl/seq_det_sat_counter.sv
// seq_det_sat_counter
//   Saturating event counter with a sticky "reached all-ones" flag.
//   Ports:
//     CLK, RST  clock, synchronous active-high reset
//     i_clr     synchronous clear of count and flag (wins over i_inc)
//     i_inc     count one event
//     o_cnt     current count, holds at all-ones
//     o_sat     set when the count reaches all-ones, held until clear/reset
module seq_det_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    always_ff @(posedge CLK) begin
        if (RST || i_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
            // Flag rises together with the count landing on all-ones.
            if (r_cnt == CNT_MAX - 1'b1)
                r_sat <= 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = r_sat;
endmodule

// File: rtl/seq_detector.sv
// seq_detector
//   Serial pattern detector. A PAT_W-bit pattern is loaded with PAT_LOAD;
//   afterwards every EN-qualified In1 bit is shifted into a history
//   register, and a match fires once PAT_W samples have been seen and the
//   history equals the pattern (PAT_IN[PAT_W-1] = oldest sample).
//   Ports:
//     CLK, RST  clock, synchronous active-high reset
//     bus       seq_detector_if.slave:
//                 EN/In1      qualified serial input
//                 PAT_LOAD    load PAT_IN, restart matching
//                 CNT_CLR     clear MATCH_CNT/CNT_SAT
//                 Out1        one-cycle match pulse (registered)
//                 MATCH_CNT   saturating match count
//                 CNT_SAT     sticky count-saturated flag
//                 ARMED       pattern loaded (state RUN)
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W   = DEF_PAT_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter bit OVERLAP = DEF_OVERLAP
) (
    input  logic          CLK,
    input  logic          RST,
    seq_detector_if.slave bus
);
    // Fill counter only needs to reach PAT_W, where it saturates.
    localparam int                FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    state_t            r_state;
    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_out1;
    logic              r_armed;

    state_t            w_state_nxt;
    logic [PAT_W-1:0]  w_pat_nxt;
    logic [PAT_W-1:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_match;
    logic [PAT_W-1:0]  w_hist_upd;
    logic [FILL_W-1:0] w_fill_upd;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_sat;

    // State register and datapath flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= UNCONF;
            r_pat   <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_out1  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pat   <= w_pat_nxt;
            r_hist  <= w_hist_nxt;
            r_fill  <= w_fill_nxt;
            r_out1  <= w_match;
            // Registered copy of the state so ARMED comes straight off a flop.
            r_armed <= (w_state_nxt == RUN);
        end
    end

    // Candidate values for an accepted sample; the match test looks at the
    // post-shift history so the pulse lines up with the completing bit.
    assign w_hist_upd = {r_hist[PAT_W-2:0], bus.In1};
    assign w_fill_upd = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_hist_nxt  = r_hist;
        w_fill_nxt  = r_fill;
        w_match     = 1'b0;

        unique case (r_state)
            UNCONF: begin
                if (bus.PAT_LOAD) begin
                    w_state_nxt = RUN;
                    w_pat_nxt   = bus.PAT_IN;
                    w_hist_nxt  = '0;
                    w_fill_nxt  = '0;
                end
            end
            RUN: begin
                // A load restarts matching and swallows any sample offered
                // in the same cycle.
                if (bus.PAT_LOAD) begin
                    w_pat_nxt  = bus.PAT_IN;
                    w_hist_nxt = '0;
                    w_fill_nxt = '0;
                end else if (bus.EN) begin
                    w_hist_nxt = w_hist_upd;
                    w_fill_nxt = w_fill_upd;
                    if ((w_fill_upd == FILL_MAX) && (w_hist_upd == r_pat)) begin
                        w_match = 1'b1;
                        // Non-overlapping mode: demand PAT_W fresh samples.
                        if (!OVERLAP)
                            w_fill_nxt = '0;
                    end
                end
            end
            default: w_state_nxt = UNCONF;
        endcase
    end

    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .i_clr (bus.CNT_CLR),
        .i_inc (w_match),
        .o_cnt (w_cnt),
        .o_sat (w_sat)
    );

    assign bus.Out1      = r_out1;
    assign bus.ARMED     = r_armed;
    assign bus.MATCH_CNT = w_cnt;
    assign bus.CNT_SAT   = w_sat;
endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector
//   Three detector instances share one stimulus stream:
//     ov  : PAT_W=4, CNT_W=8, OVERLAP=1
//     nov : PAT_W=4, CNT_W=8, OVERLAP=0
//     sat : PAT_W=4, CNT_W=2, OVERLAP=1
//   Expected Out1 for each instance is pushed to a queue as a bit is
//   driven and popped once the registered output is visible.
module tb_seq_detector;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       en = 1'b0, in1 = 1'b0, pat_load = 1'b0, cnt_clr = 1'b0;
    logic [3:0] pat_in = 4'b0000;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic ov;
        logic nov;
        logic sat;
    } exp_t;
    exp_t q[$];

    always #5 CLK = ~CLK;

    seq_detector_if #(.PAT_W(4), .CNT_W(8)) if_ov  ();
    seq_detector_if #(.PAT_W(4), .CNT_W(8)) if_nov ();
    seq_detector_if #(.PAT_W(4), .CNT_W(2)) if_sat ();

    assign if_ov.EN  = en;  assign if_ov.In1  = in1; assign if_ov.PAT_LOAD  = pat_load;
    assign if_ov.PAT_IN  = pat_in; assign if_ov.CNT_CLR  = cnt_clr;
    assign if_nov.EN = en;  assign if_nov.In1 = in1; assign if_nov.PAT_LOAD = pat_load;
    assign if_nov.PAT_IN = pat_in; assign if_nov.CNT_CLR = cnt_clr;
    assign if_sat.EN = en;  assign if_sat.In1 = in1; assign if_sat.PAT_LOAD = pat_load;
    assign if_sat.PAT_IN = pat_in; assign if_sat.CNT_CLR = cnt_clr;

    seq_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b1)) u_ov  (.CLK(CLK), .RST(RST), .bus(if_ov));
    seq_detector #(.PAT_W(4), .CNT_W(8), .OVERLAP(1'b0)) u_nov (.CLK(CLK), .RST(RST), .bus(if_nov));
    seq_detector #(.PAT_W(4), .CNT_W(2), .OVERLAP(1'b1)) u_sat (.CLK(CLK), .RST(RST), .bus(if_sat));

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic e, input logic b, input logic ld,
                         input logic c, input logic [3:0] p);
        @(negedge CLK);
        en = e; in1 = b; pat_load = ld; cnt_clr = c; pat_in = p;
        @(posedge CLK);
        #1;
        en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1; en = 1'b1; in1 = 1'b1; pat_load = 1'b1; pat_in = 4'b1011; cnt_clr = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_tests++;
        if (if_ov.ARMED !== 1'b0 || if_nov.ARMED !== 1'b0 || if_sat.ARMED !== 1'b0) begin
            n_fail++; $display("FAIL reset_armed: got %b%b%b want 000", if_ov.ARMED, if_nov.ARMED, if_sat.ARMED);
        end
        n_tests++;
        if (if_ov.Out1 !== 1'b0 || if_nov.Out1 !== 1'b0 || if_sat.Out1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_out1: got %b%b%b want 000", if_ov.Out1, if_nov.Out1, if_sat.Out1);
        end
        n_tests++;
        if (if_ov.MATCH_CNT !== 8'd0 || if_sat.MATCH_CNT !== 2'd0 || if_sat.CNT_SAT !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt: got ov=%0d sat=%0d flag=%b want 0 0 0", if_ov.MATCH_CNT, if_sat.MATCH_CNT, if_sat.CNT_SAT);
        end
        @(negedge CLK);
        RST = 1'b0; en = 1'b0; pat_load = 1'b0;
    endtask

    // Stream a matching sequence while unconfigured: nothing may happen.
    task automatic test_unconf();
        logic [3:0] bits = 4'b1011;
        exp_t e;
        for (int i = 3; i >= 0; i--) begin
            q.push_back('{1'b0, 1'b0, 1'b0});
            drive(1'b1, bits[i], 1'b0, 1'b0, 4'b1011);
            e = q.pop_front();
            n_tests++;
            if (if_ov.Out1 !== e.ov || if_ov.ARMED !== 1'b0) begin
                n_fail++; $display("FAIL unconf_bit%0d: out1=%b armed=%b want %b 0", 3 - i, if_ov.Out1, if_ov.ARMED, e.ov);
            end
        end
    endtask

    task automatic check_stream(input string name, input int n, input logic [15:0] en_v,
                                input logic [15:0] bit_v, input logic [15:0] clr_v,
                                input logic [15:0] e_ov, input logic [15:0] e_nov,
                                input logic [15:0] e_sat);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            q.push_back('{e_ov[i], e_nov[i], e_sat[i]});
            drive(en_v[i], bit_v[i], 1'b0, clr_v[i], 4'b1011);
            e = q.pop_front();
            n_tests++;
            if (if_ov.Out1 !== e.ov || if_nov.Out1 !== e.nov || if_sat.Out1 !== e.sat) begin
                n_fail++;
                $display("FAIL %s_bit%0d: out1 ov/nov/sat=%b%b%b want %b%b%b", name, i,
                         if_ov.Out1, if_nov.Out1, if_sat.Out1, e.ov, e.nov, e.sat);
            end
        end
    endtask

    task automatic load_pattern(input string name);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'b1011);
        n_tests++;
        if (if_ov.ARMED !== 1'b1 || if_nov.ARMED !== 1'b1 || if_sat.ARMED !== 1'b1 || if_ov.Out1 !== 1'b0) begin
            n_fail++; $display("FAIL %s_load: armed=%b%b%b out1=%b want 111 0", name,
                               if_ov.ARMED, if_nov.ARMED, if_sat.ARMED, if_ov.Out1);
        end
    endtask

    task automatic check_counts(input string name, input logic [7:0] c_ov, input logic [7:0] c_nov,
                                input logic [1:0] c_sat, input logic f_sat);
        n_tests++;
        if (if_ov.MATCH_CNT !== c_ov || if_nov.MATCH_CNT !== c_nov || if_sat.MATCH_CNT !== c_sat ||
            if_sat.CNT_SAT !== f_sat || if_ov.CNT_SAT !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_cnt: ov=%0d nov=%0d sat=%0d flag=%b ovflag=%b want %0d %0d %0d %b 0", name,
                     if_ov.MATCH_CNT, if_nov.MATCH_CNT, if_sat.MATCH_CNT, if_sat.CNT_SAT, if_ov.CNT_SAT,
                     c_ov, c_nov, c_sat, f_sat);
        end
    endtask

    // Stream 1,0,1,1,0,1,1: overlap hits at bits 4 and 7, non-overlap only at 4.
    task automatic test_overlap();
        load_pattern("overlap");
        check_stream("overlap", 7, 16'h7F, 16'b1101101, 16'h0,
                     16'b1001000, 16'b0001000, 16'b1001000);
        check_counts("overlap", 8'd2, 8'd1, 2'd2, 1'b0);
    endtask

    // 1,0,1 then three idle cycles with a toggling data line, then 1.
    task automatic test_en_gap();
        load_pattern("en_gap");
        check_stream("en_gap", 7, 16'b1000111, 16'b1010101, 16'h0,
                     16'b1000000, 16'b1000000, 16'b1000000);
        check_counts("en_gap", 8'd3, 8'd2, 2'd3, 1'b1);
    endtask

    // Two more overlap hits (5 total); CNT_W=2 instance stays pinned at 3.
    task automatic test_saturate();
        check_stream("saturate", 6, 16'h3F, 16'b110110, 16'h0,
                     16'b100100, 16'b100000, 16'b100100);
        check_counts("saturate", 8'd5, 8'd3, 2'd3, 1'b1);
        check_stream("clear", 1, 16'h0, 16'h0, 16'h1, 16'h0, 16'h0, 16'h0);
        check_counts("clear", 8'd0, 8'd0, 2'd0, 1'b0);
    endtask

    // Clear lands on the completing bit: pulse still fires, count stays 0.
    task automatic test_clr_match();
        check_stream("clr_match", 3, 16'h7, 16'b110, 16'b100,
                     16'b100, 16'b000, 16'b100);
        check_counts("clr_match", 8'd0, 8'd0, 2'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        load_pattern("rst_mid");
        check_stream("rst_mid_pre", 6, 16'h3F, 16'b101101, 16'h0,
                     16'b001000, 16'b001000, 16'b001000);
        check_counts("rst_mid_pre", 8'd1, 8'd1, 2'd1, 1'b0);
        @(negedge CLK);
        RST = 1'b1; en = 1'b1; in1 = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0; en = 1'b0;
        check_counts("rst_mid", 8'd0, 8'd0, 2'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011);
            n_tests++;
            if (if_ov.ARMED !== 1'b0 || if_nov.ARMED !== 1'b0 || if_sat.ARMED !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_armed%0d: got %b%b%b want 000", i, if_ov.ARMED, if_nov.ARMED, if_sat.ARMED);
            end
        end
        load_pattern("rst_mid_reload");
        check_stream("rst_mid_post", 4, 16'hF, 16'b1101, 16'h0,
                     16'b1000, 16'b1000, 16'b1000);
    endtask

    // Load with a simultaneous sample: the sample must be dropped, so
    // 0,1,1 afterwards does not complete 1011.
    task automatic test_load_with_en();
        exp_t e;
        q.push_back('{1'b0, 1'b0, 1'b0});
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1011);
        e = q.pop_front();
        n_tests++;
        if (if_ov.Out1 !== e.ov || if_ov.ARMED !== 1'b1) begin
            n_fail++; $display("FAIL load_en: out1=%b armed=%b want %b 1", if_ov.Out1, if_ov.ARMED, e.ov);
        end
        check_stream("load_en", 7, 16'h7F, 16'b1101110, 16'h0,
                     16'b1000000, 16'b1000000, 16'b1000000);
    endtask

    initial begin
        test_reset();
        test_unconf();
        test_overlap();
        test_en_gap();
        test_saturate();
        test_clr_match();
        test_reset_mid();
        test_load_with_en();
        if (q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d entries left want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at 100000 want finished");
        $fatal(1, "timeout");
    end
endmodule
